// File: rtl/cdb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cdb_arbiter                                                     |
// | Brief    : Per-unit result FIFOs feeding one registered CDB broadcast slot |
// |            through a round-robin grant.                                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cdb_arbiter #(
    parameter int N_REQ = 4,
    parameter int DEPTH = 2,
    parameter int IDX_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*32-1:0]        req_data,
    input  logic [N_REQ*IDX_W-1:0]     req_rob_idx,
    input  logic [N_REQ*5-1:0]         req_rd_addr,
    input  logic [N_REQ-1:0]           req_br_en,
    output logic                       cdb_valid,
    output logic [31:0]                cdb_data,
    output logic [IDX_W-1:0]           cdb_rob_idx,
    output logic [4:0]                 cdb_rd_addr,
    output logic                       cdb_br_en,
    output logic [$clog2(N_REQ)-1:0]   cdb_src
);

    localparam int SRC_W = $clog2(N_REQ);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = 32 + IDX_W + 5 + 1;

    logic [N_REQ-1:0]       w_ready;
    logic [N_REQ-1:0]       w_nonempty;
    logic [N_REQ-1:0]       w_grant;
    logic [N_REQ*ENT_W-1:0] w_head;
    logic [ENT_W-1:0]       w_sel;
    logic                   w_found;
    logic [SRC_W-1:0]       w_winner;
    logic [SRC_W-1:0]       w_rr_next;
    logic [SRC_W-1:0]       r_rr_ptr;
    int                     w_idx;

    // Ready is held low for the whole reset assertion, not just until the first edge.
    assign req_ready = w_ready & {N_REQ{~rst}};

    for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
        logic [ENT_W-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0] r_wptr;
        logic [PTR_W-1:0] r_rptr;
        logic [CNT_W-1:0] r_count;
        logic             w_push;
        logic             w_pop;

        assign w_ready[i]    = (r_count < CNT_W'(DEPTH));
        assign w_nonempty[i] = (r_count != '0);
        assign w_head[i*ENT_W +: ENT_W] = r_mem[r_rptr];
        assign w_push = req_valid[i] && req_ready[i] && !flush;
        assign w_pop  = w_grant[i] && !flush;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wptr] <= {req_br_en[i], req_rd_addr[i*5 +: 5],
                                  req_rob_idx[i*IDX_W +: IDX_W], req_data[i*32 +: 32]};
            end
        end
    end

    // First non-empty FIFO at or after the round-robin pointer wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        w_grant  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % N_REQ;
            if (!w_found && w_nonempty[w_idx]) begin
                w_found  = 1'b1;
                w_winner = SRC_W'(w_idx);
            end
        end
        if (w_found) w_grant[w_winner] = 1'b1;
    end

    assign w_rr_next = (w_winner == SRC_W'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
    assign w_sel     = w_head[int'(w_winner)*ENT_W +: ENT_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid   <= 1'b0;
            cdb_data    <= '0;
            cdb_rob_idx <= '0;
            cdb_rd_addr <= '0;
            cdb_br_en   <= 1'b0;
            cdb_src     <= '0;
            r_rr_ptr    <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
            r_rr_ptr  <= '0;
        end else if (w_found) begin
            cdb_valid <= 1'b1;
            {cdb_br_en, cdb_rd_addr, cdb_rob_idx, cdb_data} <= w_sel;
            cdb_src   <= w_winner;
            r_rr_ptr  <= w_rr_next;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cdb_arbiter                                                  |
// | Brief    : Directed bench for cdb_arbiter with hand-computed expectations. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_cdb_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_data;
    logic [19:0]  req_rob_idx;
    logic [19:0]  req_rd_addr;
    logic [3:0]   req_br_en;
    logic         cdb_valid;
    logic [31:0]  cdb_data;
    logic [4:0]   cdb_rob_idx;
    logic [4:0]   cdb_rd_addr;
    logic         cdb_br_en;
    logic [1:0]   cdb_src;

    int total = 0;
    int bad   = 0;

    cdb_arbiter #(.N_REQ(4), .DEPTH(2), .IDX_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_rob_idx(req_rob_idx), .req_rd_addr(req_rd_addr), .req_br_en(req_br_en),
        .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_rob_idx(cdb_rob_idx),
        .cdb_rd_addr(cdb_rd_addr), .cdb_br_en(cdb_br_en), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ent_data(int u, int e);
        return 32'hA000_0000 | (u << 8) | e;
    endfunction
    function automatic logic [4:0] ent_rob(int u, int e);
        return 5'(u * 4 + e);
    endfunction
    function automatic logic [4:0] ent_rd(int u, int e);
        return 5'(u * 2 + e + 1);
    endfunction
    function automatic logic ent_br(int u, int e);
        return (u == 2) && (e == 1);
    endfunction

    task automatic clear_inputs();
        req_valid = '0; req_data = '0; req_rob_idx = '0; req_rd_addr = '0; req_br_en = '0;
    endtask

    task automatic set_unit(int u, logic [31:0] d, logic [4:0] rob, logic [4:0] rd, logic br);
        req_valid[u] = 1'b1;
        req_data[u*32 +: 32]   = d;
        req_rob_idx[u*5 +: 5]  = rob;
        req_rd_addr[u*5 +: 5]  = rd;
        req_br_en[u]           = br;
    endtask

    task automatic set_entry(int u, int e);
        set_unit(u, ent_data(u, e), ent_rob(u, e), ent_rd(u, e), ent_br(u, e));
    endtask

    // Leaves the bench at the falling edge right after the flush edge.
    task automatic do_flush();
        @(negedge clk);
        clear_inputs();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; clear_inputs();
        #3;
        total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", cdb_valid); end
        total++; if ({cdb_data, cdb_rob_idx, cdb_rd_addr, cdb_br_en, cdb_src} !== '0) begin
            bad++; $display("FAIL reset_payload got=%h/%h/%h/%b/%0d exp=0", cdb_data, cdb_rob_idx, cdb_rd_addr, cdb_br_en, cdb_src); end
        total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 4'hF) begin bad++; $display("FAIL ready_after_reset got=%b exp=1111", req_ready); end
    endtask

    task automatic test_single();
        do_flush();
        set_unit(0, 32'h1234_5678, 5'd3, 5'd5, 1'b0);
        @(negedge clk);
        clear_inputs();
        total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL single_not_eligible got=%b exp=0", cdb_valid); end
        @(negedge clk);
        total++; if ({cdb_valid, cdb_src, cdb_data, cdb_rob_idx, cdb_rd_addr, cdb_br_en} !== {1'b1, 2'd0, 32'h1234_5678, 5'd3, 5'd5, 1'b0}) begin
            bad++; $display("FAIL single_bcast got v=%b src=%0d d=%h rob=%0d rd=%0d br=%b exp v=1 src=0 d=12345678 rob=3 rd=5 br=0",
                            cdb_valid, cdb_src, cdb_data, cdb_rob_idx, cdb_rd_addr, cdb_br_en); end
        @(negedge clk);
        total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL single_after got=%b exp=0", cdb_valid); end
        total++; if (cdb_data !== 32'h1234_5678) begin bad++; $display("FAIL single_hold got=%h exp=12345678", cdb_data); end
    endtask

    task automatic test_all_four();
        do_flush();
        for (int u = 0; u < 4; u++) set_entry(u, 0);
        @(negedge clk);
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if ({cdb_valid, cdb_src, cdb_data, cdb_rob_idx} !== {1'b1, 2'(k), ent_data(k, 0), ent_rob(k, 0)}) begin
                bad++; $display("FAIL all_four_%0d got v=%b src=%0d d=%h rob=%0d exp v=1 src=%0d d=%h rob=%0d",
                                k, cdb_valid, cdb_src, cdb_data, cdb_rob_idx, k, ent_data(k, 0), ent_rob(k, 0)); end
        end
        @(negedge clk);
        total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL all_four_idle got=%b exp=0", cdb_valid); end
    endtask

    task automatic test_rr_skip();
        int seq[4];
        int exp_seq[4];
        logic [3:0] acc;
        int order[3];
        int s;
        order = '{0, 1, 3};
        for (int u = 0; u < 4; u++) begin seq[u] = 0; exp_seq[u] = 0; end
        do_flush();
        for (int c = 1; c <= 18; c++) begin
            clear_inputs();
            foreach (order[j]) set_unit(order[j], 32'hB000_0000 | (order[j] << 16) | seq[order[j]], 5'd0, 5'd0, 1'b0);
            acc = req_valid & req_ready;
            @(negedge clk);
            for (int u = 0; u < 4; u++) if (acc[u]) seq[u]++;
            if (c == 1) begin
                total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL rr_first got=%b exp=0", cdb_valid); end
            end else begin
                s = order[(c - 2) % 3];
                total++; if ({cdb_valid, cdb_src, cdb_data} !== {1'b1, 2'(s), 32'hB000_0000 | (s << 16) | exp_seq[s]}) begin
                    bad++; $display("FAIL rr_cycle_%0d got v=%b src=%0d d=%h exp v=1 src=%0d d=%h",
                                    c, cdb_valid, cdb_src, cdb_data, s, 32'hB000_0000 | (s << 16) | exp_seq[s]); end
                exp_seq[s]++;
            end
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        int exp_src[9];
        int exp_ent[9];
        logic mem_done;
        logic acc;
        int s;
        int e;
        exp_src  = '{0, 1, 2, 3, 0, 1, 2, 3, 3};
        exp_ent  = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
        mem_done = 1'b0;
        do_flush();
        for (int c = 1; c <= 11; c++) begin
            clear_inputs();
            if (c <= 2) for (int u = 0; u < 4; u++) set_entry(u, c - 1);
            else if (!mem_done) set_entry(3, 2);
            if (c >= 3 && c <= 6) begin
                total++; if (req_ready[3] !== (c == 6)) begin
                    bad++; $display("FAIL b2b_mem_ready_%0d got=%b exp=%b", c, req_ready[3], (c == 6)); end
            end
            acc = req_valid[3] && req_ready[3];
            @(negedge clk);
            if (c > 2 && acc) mem_done = 1'b1;
            if (c >= 2 && c <= 10) begin
                s = exp_src[c - 2];
                e = exp_ent[c - 2];
                total++; if ({cdb_valid, cdb_src, cdb_data, cdb_rob_idx, cdb_rd_addr, cdb_br_en} !==
                             {1'b1, 2'(s), ent_data(s, e), ent_rob(s, e), ent_rd(s, e), ent_br(s, e)}) begin
                    bad++; $display("FAIL b2b_edge_%0d got v=%b src=%0d d=%h rob=%0d rd=%0d br=%b exp v=1 src=%0d d=%h rob=%0d rd=%0d br=%b",
                                    c, cdb_valid, cdb_src, cdb_data, cdb_rob_idx, cdb_rd_addr, cdb_br_en,
                                    s, ent_data(s, e), ent_rob(s, e), ent_rd(s, e), ent_br(s, e)); end
            end else begin
                total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle_%0d got=%b exp=0", c, cdb_valid); end
            end
        end
        clear_inputs();
    endtask

    task automatic test_flush();
        do_flush();
        for (int u = 0; u < 4; u++) set_entry(u, 0);
        @(negedge clk);
        for (int u = 0; u < 4; u++) set_entry(u, 1);
        @(negedge clk);
        clear_inputs();
        for (int u = 0; u < 4; u++) set_unit(u, 32'hDEAD_0000, 5'd31, 5'd31, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        clear_inputs();
        total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", cdb_valid); end
        total++; if (req_ready !== 4'hF) begin bad++; $display("FAIL flush_ready got=%b exp=1111", req_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL flush_stale_%0d got v=%b rob=%0d exp v=0", k, cdb_valid, cdb_rob_idx); end
        end
        for (int u = 0; u < 4; u++) set_unit(u, 32'hC000_0000 | u, 5'(16 + u), 5'd1, 1'b0);
        @(negedge clk);
        clear_inputs();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++; if ({cdb_valid, cdb_src, cdb_rob_idx} !== {1'b1, 2'(k), 5'(16 + k)}) begin
                bad++; $display("FAIL flush_regrant_%0d got v=%b src=%0d rob=%0d exp v=1 src=%0d rob=%0d",
                                k, cdb_valid, cdb_src, cdb_rob_idx, k, 16 + k); end
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        do_flush();
        for (int u = 0; u < 4; u++) set_entry(u, 0);
        @(negedge clk);
        for (int u = 0; u < 4; u++) set_entry(u, 1);
        @(negedge clk);
        clear_inputs();
        total++; if (cdb_valid !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got=%b exp=1", cdb_valid); end
        #2;
        rst = 1'b1;
        #1;
        total++; if ({cdb_valid, cdb_data, cdb_rob_idx, cdb_rd_addr, cdb_br_en, cdb_src} !== '0) begin
            bad++; $display("FAIL rst_mid_async got v=%b d=%h rob=%0d rd=%0d br=%b src=%0d exp all 0",
                            cdb_valid, cdb_data, cdb_rob_idx, cdb_rd_addr, cdb_br_en, cdb_src); end
        total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL rst_mid_ready got=%b exp=0000", req_ready); end
        @(negedge clk);
        total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL rst_hold_ready got=%b exp=0000", req_ready); end
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 4'hF) begin bad++; $display("FAIL rst_release_ready got=%b exp=1111", req_ready); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL rst_empty_%0d got=%b exp=0", k, cdb_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_rr_skip();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
